mem_arbiter: RTL

Sequences the single shared memory path (RAM plus memory-mapped serial behind the MMU) between the instruction-fetch port and the MEM-stage data port of the pipeline. Accepts one request at a time, holds address/data/direction stable for a fixed multi-cycle access window, captures read data, and returns a one-cycle ready pulse to the granted requester. Drives the pipeline stall request while any requester is waiting. Sits between the IF/MEM stages and the MMU's upper interface.

---
 rtl/mem_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Shares the single MMU memory path between instruction fetch and the MEM-stage
// data port: one transaction at a time, fixed-length access window, one-cycle ready.
module mem_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_data_o,
  output logic              if_ready_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_ready_o,
  output logic              stall_o,
  output logic              memEnable_o,
  output logic              memReadWrite_o,
  output logic [ADDR_W-1:0] memAddress_o,
  output logic [DATA_W-1:0] memDataWrite_o,
  input  logic [DATA_W-1:0] memDataRead_i
);

  // Handshake: a requester holds req and operands from assertion through its ready
  // cycle; ready is a single-cycle pulse, and req still high after it starts a new access.

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [2:0]        r_cnt;
  logic              r_last_mem;
  logic              r_grant_mem;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_if_data;
  logic [DATA_W-1:0] r_mem_rdata;

  logic w_start;
  logic w_pick_mem;
  logic w_capture;
  logic w_access;

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_pick_mem  = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (if_req_i || mem_req_i) begin
          w_start     = 1'b1;
          // MEM wins a tie unless it also took the previous grant.
          w_pick_mem  = mem_req_i && (!if_req_i || !r_last_mem);
          w_state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (r_cnt == 3'd0) begin
          w_capture   = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 3'd0;
      r_last_mem  <= 1'b0;
      r_grant_mem <= 1'b0;
      r_we        <= MEM_READ;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_if_data   <= '0;
      r_mem_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_cnt       <= 3'(WAIT_CYCLES);
        r_grant_mem <= w_pick_mem;
        r_last_mem  <= w_pick_mem;
        r_we        <= w_pick_mem ? mem_we_i : MEM_READ;
        r_addr      <= w_pick_mem ? mem_addr_i : if_addr_i;
        r_wdata     <= w_pick_mem ? mem_wdata_i : '0;
      end else if (r_state == S_ACCESS && r_cnt != 3'd0) begin
        r_cnt <= r_cnt - 3'd1;
      end
      if (w_capture && r_we == MEM_READ) begin
        if (r_grant_mem) r_mem_rdata <= memDataRead_i;
        else             r_if_data   <= memDataRead_i;
      end
    end
  end

  // MMU outputs come straight from state so an async reset drops enable at once.
  assign w_access       = (r_state == S_ACCESS);
  assign memEnable_o    = w_access;
  assign memReadWrite_o = w_access ? r_we : MEM_READ;
  assign memAddress_o   = w_access ? r_addr : '0;
  assign memDataWrite_o = w_access ? r_wdata : '0;

  assign if_ready_o  = (r_state == S_RESP) && !r_grant_mem;
  assign mem_ready_o = (r_state == S_RESP) &&  r_grant_mem;
  assign if_data_o   = r_if_data;
  assign mem_rdata_o = r_mem_rdata;

  assign stall_o = (if_req_i && !if_ready_o) || (mem_req_i && !mem_ready_o);

endmodule
